// File: rtl/vx_gbar_collector_if.sv
// Global-barrier bus between core schedulers (master) and the cluster collector (slave).
// Carries the arrival request channel and the broadcast release pulse.
interface vx_gbar_collector_if #(
  parameter int NB_WIDTH = 2,
  parameter int NC_WIDTH = 2
);
  logic                req_valid;
  logic                req_ready;
  logic [NB_WIDTH-1:0] req_id;
  logic [NC_WIDTH-1:0] req_size_m1;
  logic [NC_WIDTH-1:0] req_core_id;
  logic                rsp_valid;
  logic [NB_WIDTH-1:0] rsp_id;

  modport master (
    output req_valid, req_id, req_size_m1, req_core_id,
    input  req_ready, rsp_valid, rsp_id
  );

  modport slave (
    input  req_valid, req_id, req_size_m1, req_core_id,
    output req_ready, rsp_valid, rsp_id
  );
endinterface

// File: rtl/vx_gbar_collector.sv
// Cluster-level global barrier collector: tracks per-ID core arrival masks and
// broadcasts a one-cycle release once the latched participant count is reached.
module vx_gbar_collector #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  vx_gbar_collector_if.slave      bus,
  output logic [NUM_BARRIERS-1:0] active_mask,
  output logic                    busy,
  output logic                    err_dup,
  output logic                    err_size
);

  localparam int CW = NC_WIDTH + 1;
  localparam logic [NB_WIDTH:0] NB_LIMIT = (NB_WIDTH + 1)'(NUM_BARRIERS);
  localparam logic [NC_WIDTH:0] NC_LIMIT = (NC_WIDTH + 1)'(NUM_CORES);

  logic                    ready_reg;
  logic                    rsp_valid_reg;
  logic [NB_WIDTH-1:0]     rsp_id_reg;
  logic                    err_dup_reg;
  logic                    err_size_reg;

  logic                    in_range;
  logic                    accept;
  logic [NUM_CORES-1:0]    core_onehot;
  logic [NUM_BARRIERS-1:0] release_vec;
  logic [NUM_BARRIERS-1:0] dup_vec;
  logic [NUM_BARRIERS-1:0] size_err_vec;
  logic [NB_WIDTH-1:0]     release_id;

  // Out-of-range IDs are dropped here so no per-barrier slot ever sees them.
  assign in_range = ({1'b0, bus.req_id} < NB_LIMIT) && ({1'b0, bus.req_core_id} < NC_LIMIT);
  assign accept   = bus.req_valid && ready_reg && in_range;

  always_comb begin
    core_onehot = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_onehot[i] = (bus.req_core_id == NC_WIDTH'(i));
    end
  end

  for (genvar gi = 0; gi < NUM_BARRIERS; gi++) begin : g_bar
    logic [NUM_CORES-1:0] mask_reg;
    logic [NC_WIDTH-1:0]  size_reg;
    logic                 hit;
    logic                 collecting;
    logic                 dup;
    logic [NC_WIDTH-1:0]  eff_size;
    logic [NUM_CORES-1:0] mask_next;
    logic [CW-1:0]        cnt;

    assign hit        = accept && (bus.req_id == NB_WIDTH'(gi));
    assign collecting = |mask_reg;
    // An idle barrier adopts the requester's size; a collecting one keeps its own.
    assign eff_size   = collecting ? size_reg : bus.req_size_m1;
    assign dup        = collecting && |(mask_reg & core_onehot);
    assign mask_next  = mask_reg | core_onehot;

    always_comb begin
      cnt = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        cnt = cnt + CW'(mask_next[i]);
      end
    end

    assign release_vec[gi]  = hit && !dup && (cnt == ({1'b0, eff_size} + CW'(1)));
    assign dup_vec[gi]      = hit && dup;
    assign size_err_vec[gi] = hit && collecting && (bus.req_size_m1 != size_reg);
    assign active_mask[gi]  = collecting;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        mask_reg <= '0;
        size_reg <= '0;
      end else if (hit && !dup) begin
        mask_reg <= release_vec[gi] ? '0 : mask_next;
        if (!collecting) begin
          size_reg <= bus.req_size_m1;
        end
      end
    end
  end

  // At most one acceptance per cycle, so at most one bit of release_vec is set.
  always_comb begin
    release_id = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      if (release_vec[i]) begin
        release_id = NB_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      err_dup_reg   <= 1'b0;
      err_size_reg  <= 1'b0;
    end else begin
      ready_reg     <= 1'b1;
      rsp_valid_reg <= |release_vec;
      if (|release_vec) begin
        rsp_id_reg <= release_id;
      end
      if (|dup_vec) begin
        err_dup_reg <= 1'b1;
      end
      if (|size_err_vec) begin
        err_size_reg <= 1'b1;
      end
    end
  end

  assign bus.req_ready = ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign busy          = |active_mask;
  assign err_dup       = err_dup_reg;
  assign err_size      = err_size_reg;

endmodule

// File: tb/tb_vx_gbar_collector.sv
// Self-checking bench for vx_gbar_collector: directed scenarios followed by random
// traffic, all compared against a set-based barrier model.
module tb_vx_gbar_collector;
  localparam int NC  = 4;
  localparam int NB  = 4;
  localparam int NCW = 2;
  localparam int NBW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] active_mask;
  logic          busy;
  logic          err_dup;
  logic          err_size;

  vx_gbar_collector_if #(.NB_WIDTH(NBW), .NC_WIDTH(NCW)) bus ();

  vx_gbar_collector #(
    .NUM_CORES(NC), .NUM_BARRIERS(NB), .NC_WIDTH(NCW), .NB_WIDTH(NBW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .active_mask(active_mask),
    .busy(busy),
    .err_dup(err_dup),
    .err_size(err_size)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which cores have arrived at each barrier, and its agreed size.
  bit m_arr [NB][NC];
  int m_size [NB];
  bit m_ready;
  bit m_err_dup;
  bit m_err_size;
  bit exp_v;
  int exp_id;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int m_count(int id);
    int n = 0;
    for (int c = 0; c < NC; c++) n += int'(m_arr[id][c]);
    return n;
  endfunction

  function automatic logic [31:0] m_active();
    logic [31:0] a = '0;
    for (int b = 0; b < NB; b++) a[b] = (m_count(b) != 0);
    return a;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < NB; b++) begin
      m_size[b] = 0;
      for (int c = 0; c < NC; c++) m_arr[b][c] = 1'b0;
    end
    m_ready = 1'b0;
    m_err_dup = 1'b0;
    m_err_size = 1'b0;
    exp_v = 1'b0;
    exp_id = 0;
  endtask

  task automatic model_edge(bit v, int id, int sz, int core);
    int eff;
    exp_v = 1'b0;
    if (v && m_ready && id < NB && core < NC) begin
      if (m_count(id) == 0) begin
        eff = sz;
        m_size[id] = sz;
      end else begin
        eff = m_size[id];
        if (sz != eff) m_err_size = 1'b1;
      end
      if (m_arr[id][core]) begin
        m_err_dup = 1'b1;
      end else begin
        m_arr[id][core] = 1'b1;
        if (m_count(id) == eff + 1) begin
          for (int c = 0; c < NC; c++) m_arr[id][c] = 1'b0;
          exp_v = 1'b1;
          exp_id = id;
        end
      end
    end
    m_ready = 1'b1;
  endtask

  task automatic step(bit v, int id, int sz, int core);
    bus.req_valid   = v;
    bus.req_id      = id[NBW-1:0];
    bus.req_size_m1 = sz[NCW-1:0];
    bus.req_core_id = core[NCW-1:0];
    model_edge(v, id, sz, core);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    $display("t=%0t req v=%0d id=%0d sz=%0d core=%0d | rsp v=%0d id=%0d act=%b dup=%0d size=%0d",
             $time, v, id, sz, core, bus.rsp_valid, bus.rsp_id, active_mask, err_dup, err_size);
    check_val("req_ready", {31'd0, bus.req_ready}, 1);
    check_val("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, exp_v});
    if (exp_v) check_val("rsp_id", {30'd0, bus.rsp_id}, exp_id);
    check_val("active_mask", {28'd0, active_mask}, m_active());
    check_val("busy", {31'd0, busy}, {31'd0, m_active() != 0});
    check_val("err_dup", {31'd0, err_dup}, {31'd0, m_err_dup});
    check_val("err_size", {31'd0, err_size}, {31'd0, m_err_size});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    model_clear();
    #1;
    $display("t=%0t reset asserted", $time);
    check_val("rst_req_ready", {31'd0, bus.req_ready}, 0);
    check_val("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    check_val("rst_rsp_id", {30'd0, bus.rsp_id}, 0);
    check_val("rst_active", {28'd0, active_mask}, 0);
    check_val("rst_busy", {31'd0, busy}, 0);
    check_val("rst_err_dup", {31'd0, err_dup}, 0);
    check_val("rst_err_size", {31'd0, err_size}, 0);
    @(posedge clk);
    #1;
    check_val("rst_hold_ready", {31'd0, bus.req_ready}, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    int sz_tab [NB];
    reset_n         = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_id      = '0;
    bus.req_size_m1 = '0;
    bus.req_core_id = '0;
    model_clear();
    #2;
    do_reset();

    // First edge after reset release: not ready yet, so this request is ignored.
    step(1, 1, 0, 3);
    step(0, 0, 0, 0);

    // Reset in the middle of an episode discards it.
    step(1, 1, 2, 0);
    step(1, 1, 2, 1);
    check_val("mid_active", {28'd0, active_mask}, 32'h2);
    do_reset();
    step(0, 0, 0, 0);
    step(1, 1, 2, 0);
    step(1, 1, 2, 1);
    step(1, 1, 2, 2);
    check_val("mid_rsp_id", {30'd0, bus.rsp_id}, 1);
    step(0, 0, 0, 0);

    // Full barrier on ID2.
    for (int c = 0; c < NC; c++) step(1, 2, 3, c);
    check_val("full_rsp_valid", {31'd0, bus.rsp_valid}, 1);
    check_val("full_rsp_id", {30'd0, bus.rsp_id}, 2);
    step(0, 0, 0, 0);

    // Trivial barrier releases immediately.
    step(1, 1, 0, 3);
    check_val("triv_rsp_id", {30'd0, bus.rsp_id}, 1);
    check_val("triv_active", {28'd0, active_mask}, 0);

    // Interleaved episodes on ID0 and ID1.
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    check_val("intl_rsp1", {30'd0, bus.rsp_id}, 1);
    step(1, 0, 1, 1);
    check_val("intl_rsp0", {30'd0, bus.rsp_id}, 0);

    // Duplicate arrival, then back-to-back reuse of ID3.
    step(1, 3, 1, 0);
    step(1, 3, 1, 0);
    check_val("dup_flag", {31'd0, err_dup}, 1);
    step(1, 3, 1, 1);
    step(1, 3, 1, 2);
    check_val("reuse_active", {28'd0, active_mask}, 32'h8);
    step(1, 3, 1, 3);

    // Size mismatch: the latched size of 2 is honoured.
    step(1, 0, 2, 0);
    step(1, 0, 1, 1);
    check_val("size_flag", {31'd0, err_size}, 1);
    step(1, 0, 2, 2);
    check_val("size_rsp_id", {30'd0, bus.rsp_id}, 0);
    step(0, 0, 0, 0);

    // Random traffic with occasional resets and stray sizes.
    do_reset();
    for (int b = 0; b < NB; b++) sz_tab[b] = b;
    for (int n = 0; n < 500; n++) begin
      int id;
      int sz;
      if ($urandom_range(0, 99) == 0) do_reset();
      id = int'($urandom_range(0, NB - 1));
      sz = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, NC - 1)) : sz_tab[id];
      step($urandom_range(0, 9) < 7, id, sz, int'($urandom_range(0, NC - 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
